// File: rtl/ring_counter_param_if.sv
// ring_counter_param_if: control/data bundle between a sequencer user and ring_counter_param
interface ring_counter_param_if #(parameter int WIDTH = 4);
  logic             en;
  logic             mode;
  logic             dir;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] q;
  logic             wrap;
  logic             err;
  modport master (output en, mode, dir, load, load_val, input q, wrap, err);
  modport slave (input en, mode, dir, load, load_val, output q, wrap, err);
endinterface

// File: rtl/ring_counter_param.sv
// ring_counter_param: one-hot ring / Johnson sequencer with load, wrap pulse and optional illegal-state correction (RING_SELF_CORRECT_EN)
module ring_counter_param #(
  parameter int WIDTH = 4
) (
  input logic                  clk,
  input logic                  clr,
  ring_counter_param_if.slave  bus
);
  logic [WIDTH-1:0] q_q, q_d, home, shift;
  logic             wrap_q, wrap_d, err_q, err_d, bad;
  // next state: clr > load > en > hold; an illegal state on an enabled shift may be forced home
  always_comb begin
    home   = bus.mode ? '0 : {{(WIDTH-1){1'b0}}, 1'b1};
    shift  = bus.mode ? (bus.dir ? {~q_q[0], q_q[WIDTH-1:1]} : {q_q[WIDTH-2:0], ~q_q[WIDTH-1]})
                      : (bus.dir ? {q_q[0], q_q[WIDTH-1:1]} : {q_q[WIDTH-2:0], q_q[WIDTH-1]});
`ifdef RING_SELF_CORRECT_EN
    bad    = bus.mode ? ($countones(q_q[WIDTH-1:1] ^ q_q[WIDTH-2:0]) > 1) : !$onehot(q_q);
`else
    bad    = 1'b0;
`endif
    q_d    = clr ? home : bus.load ? bus.load_val : !bus.en ? q_q : bad ? home : shift;
    wrap_d = !clr && !bus.load && bus.en && !bad && (shift == home);
    err_d  = !clr && !bus.load && bus.en && bad;
  end
  // state and pulse registers
  always_ff @(posedge clk) begin
    q_q    <= q_d;
    wrap_q <= wrap_d;
    err_q  <= err_d;
  end
  assign bus.q    = q_q;
  assign bus.wrap = wrap_q;
  assign bus.err  = err_q;
endmodule

// File: tb/tb_ring_counter_param.sv
// tb_ring_counter_param: directed vectors with a scoreboard queue for WIDTH=4 and WIDTH=8 instances
module tb_ring_counter_param;
  logic clk = 1'b0;
  logic clr = 1'b0;
  always #5 clk = ~clk;
  ring_counter_param_if #(.WIDTH(4)) b4 ();
  ring_counter_param_if #(.WIDTH(8)) b8 ();
  ring_counter_param #(.WIDTH(4)) dut4 (.clk(clk), .clr(clr), .bus(b4));
  ring_counter_param #(.WIDTH(8)) dut8 (.clk(clk), .clr(clr), .bus(b8));
  typedef struct {
    bit          w8;
    logic [31:0] q;
    logic        wrap;
    logic        err;
    string       name;
  } exp_t;
  exp_t sb[$];
  int checks = 0;
  int errors = 0;
  // monitor: the DUT presents a new registered output every cycle; compare against the oldest expectation
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      logic [31:0] aq;
      logic aw, ae;
      e  = sb.pop_front();
      aq = e.w8 ? {24'b0, b8.q} : {28'b0, b4.q};
      aw = e.w8 ? b8.wrap : b4.wrap;
      ae = e.w8 ? b8.err : b4.err;
      checks++;
      if (aq !== e.q || aw !== e.wrap || ae !== e.err) begin
        errors++;
        $display("FAIL %s: got q=%h wrap=%b err=%b, expected q=%h wrap=%b err=%b",
                 e.name, aq, aw, ae, e.q, e.wrap, e.err);
      end
    end
  end
  task automatic step(input bit w8, input logic c, input logic l, input logic e, input logic m,
                      input logic d, input logic [31:0] lv, input logic [31:0] eq,
                      input logic ew, input logic ee, input string nm);
    exp_t x;
    @(negedge clk);
    #1;
    clr = c;
    b4.en = w8 ? 1'b0 : e; b4.load = w8 ? 1'b0 : l; b4.mode = m; b4.dir = d; b4.load_val = lv[3:0];
    b8.en = w8 ? e : 1'b0; b8.load = w8 ? l : 1'b0; b8.mode = m; b8.dir = d; b8.load_val = lv[7:0];
    x.w8 = w8; x.q = eq; x.wrap = ew; x.err = ee; x.name = nm;
    sb.push_back(x);
  endtask
  logic [7:0] j8 [16] = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF,
                          8'hFE, 8'hFC, 8'hF8, 8'hF0, 8'hE0, 8'hC0, 8'h80, 8'h00};
  logic [3:0] j4l [8] = '{4'h1, 4'h3, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8, 4'h0};
  logic [3:0] j4r [8] = '{4'h8, 4'hC, 4'hE, 4'hF, 4'h7, 4'h3, 4'h1, 4'h0};
  logic [3:0] r4l [4] = '{4'h2, 4'h4, 4'h8, 4'h1};
  logic [3:0] r4r [4] = '{4'h8, 4'h4, 4'h2, 4'h1};
  initial begin
    b4.en = 0; b4.load = 0; b4.mode = 0; b4.dir = 0; b4.load_val = '0;
    b8.en = 0; b8.load = 0; b8.mode = 0; b8.dir = 0; b8.load_val = '0;
    step(0, 1, 0, 0, 0, 0, 0, 32'h1, 0, 0, "ring_reset");
    for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 0, 0, 0, {28'b0, r4l[i]}, i == 3, 0, "ring_up");
    step(0, 1, 0, 0, 1, 0, 0, 32'h0, 0, 0, "john_reset");
    for (int i = 0; i < 8; i++) begin
      step(0, 0, 0, 1, 1, 0, 0, {28'b0, j4l[i]}, i == 7, 0, "john_up");
      if (i == 3) for (int k = 0; k < 3; k++) step(0, 0, 0, 0, 1, 0, 0, 32'hF, 0, 0, "john_hold");
    end
    for (int i = 0; i < 8; i++) step(0, 0, 0, 1, 1, 1, 0, {28'b0, j4r[i]}, i == 7, 0, "john_down");
    step(0, 1, 0, 0, 0, 1, 0, 32'h1, 0, 0, "ring_reset2");
    for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 0, 1, 0, {28'b0, r4r[i]}, i == 3, 0, "ring_down");
    step(0, 0, 1, 1, 0, 1, 32'h4, 32'h4, 0, 0, "load_beats_en");
    step(0, 0, 1, 0, 0, 0, 32'h1, 32'h1, 0, 0, "load_home_nowrap");
    step(0, 0, 1, 0, 0, 0, 32'h6, 32'h6, 0, 0, "load_illegal");
`ifdef RING_SELF_CORRECT_EN
    step(0, 0, 0, 1, 0, 0, 0, 32'h1, 0, 1, "self_correct");
    step(0, 0, 0, 1, 0, 0, 0, 32'h2, 0, 0, "after_correct");
`else
    step(0, 0, 0, 1, 0, 0, 0, 32'hC, 0, 0, "illegal_rotate");
    step(0, 0, 0, 1, 0, 0, 0, 32'h9, 0, 0, "illegal_rotate2");
`endif
    step(0, 0, 0, 0, 0, 0, 0, (`ifdef RING_SELF_CORRECT_EN 32'h2 `else 32'h9 `endif), 0, 0, "hold_err_low");
    step(0, 1, 0, 0, 0, 0, 0, 32'h1, 0, 0, "mid_reset");
    step(0, 0, 0, 1, 0, 0, 0, 32'h2, 0, 0, "mid_a");
    step(0, 0, 0, 1, 0, 0, 0, 32'h4, 0, 0, "mid_b");
    step(0, 1, 1, 1, 0, 0, 32'hF, 32'h1, 0, 0, "clr_beats_all");
    step(1, 1, 0, 0, 1, 0, 0, 32'h00, 0, 0, "j8_reset");
    for (int i = 0; i < 16; i++) step(1, 0, 0, 1, 1, 0, 0, {24'b0, j8[i]}, i == 15, 0, "j8_period");
    step(1, 0, 0, 1, 1, 0, 0, 32'h01, 0, 0, "j8_restart");
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending, expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
